// File: rtl/apb_regs_bank.sv
// apb_regs_bank: parameterised APB register bank.
//
// Holds NO_APB_REGS registers of REG_DATA_WIDTH bits each. The registers are
// reachable from APB at BASE_ADDR + i*ADDR_OFFSET. Writes honour the byte strobes.
// Registers can be made read-only (updated by hardware loads) or write-1-to-clear
// (sticky bits set by hardware). Each transfer can take WAIT_STATES extra access
// cycles. Illegal accesses complete with PSLVERR.
//
// Ports:
//   p_clk, p_rst           clock, synchronous active-high reset
//   apb_reg_*              APB slave interface (pprot is ignored)
//   reg_init_i             per-register reset values, sampled while p_rst=1
//   hw_set_i               sticky set bits for W1C registers
//   hw_ld_i/hw_ld_data_i   hardware load for READ_ONLY registers
//   reg_q_o                current register contents
//   reg_wr_pulse_o         one-cycle pulse in the cycle after a committed APB write
module apb_regs_bank #(
    parameter int unsigned                   NO_APB_REGS    = 16,
    parameter int unsigned                   APB_ADDR_WIDTH = 32,
    parameter int unsigned                   APB_DATA_WIDTH = 32,
    parameter int unsigned                   REG_DATA_WIDTH = 16,
    parameter logic [APB_ADDR_WIDTH-1:0]     BASE_ADDR      = APB_ADDR_WIDTH'(32'h0013_0000),
    parameter int unsigned                   ADDR_OFFSET    = 4,
    parameter logic [NO_APB_REGS-1:0]        READ_ONLY      = '0,
    parameter logic [NO_APB_REGS-1:0]        W1C            = '0,
    parameter int unsigned                   WAIT_STATES    = 0
) (
    input  logic                                         p_clk,
    input  logic                                         p_rst,
    input  logic [APB_ADDR_WIDTH-1:0]                    apb_reg_paddr,
    input  logic [2:0]                                   apb_reg_pprot,
    input  logic                                         apb_reg_psel,
    input  logic                                         apb_reg_penable,
    input  logic                                         apb_reg_pwrite,
    input  logic [APB_DATA_WIDTH-1:0]                    apb_reg_pwdata,
    input  logic [APB_DATA_WIDTH/8-1:0]                  apb_reg_pstrb,
    output logic                                         apb_reg_pready,
    output logic [APB_DATA_WIDTH-1:0]                    apb_reg_prdata,
    output logic                                         apb_reg_pslverr,
    input  logic [NO_APB_REGS-1:0][REG_DATA_WIDTH-1:0]   reg_init_i,
    input  logic [NO_APB_REGS-1:0][REG_DATA_WIDTH-1:0]   hw_set_i,
    input  logic [NO_APB_REGS-1:0]                       hw_ld_i,
    input  logic [NO_APB_REGS-1:0][REG_DATA_WIDTH-1:0]   hw_ld_data_i,
    output logic [NO_APB_REGS-1:0][REG_DATA_WIDTH-1:0]   reg_q_o,
    output logic [NO_APB_REGS-1:0]                       reg_wr_pulse_o
);

    localparam int unsigned STRB_W    = APB_DATA_WIDTH / 8;
    localparam int unsigned IDX_W     = (NO_APB_REGS > 1) ? $clog2(NO_APB_REGS) : 1;
    localparam int unsigned OFF_SHIFT = $clog2(ADDR_OFFSET);

    localparam logic [APB_ADDR_WIDTH-1:0] ALIGN_MASK = APB_ADDR_WIDTH'(ADDR_OFFSET - 1);
    localparam logic [APB_ADDR_WIDTH-1:0] NREGS_A    = APB_ADDR_WIDTH'(NO_APB_REGS);
    localparam logic [3:0]                WS         = 4'(WAIT_STATES);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    // Parameter legality checks at elaboration time.
    if (REG_DATA_WIDTH > APB_DATA_WIDTH) begin : g_err_reg_width
        $error("REG_DATA_WIDTH must not exceed APB_DATA_WIDTH");
    end
    if ((APB_DATA_WIDTH % 8) != 0) begin : g_err_data_width
        $error("APB_DATA_WIDTH must be a multiple of 8");
    end
    if ((ADDR_OFFSET == 0) || ((ADDR_OFFSET & (ADDR_OFFSET - 1)) != 0)) begin : g_err_offset
        $error("ADDR_OFFSET must be a power of two");
    end
    if (ADDR_OFFSET < STRB_W) begin : g_err_offset_min
        $error("ADDR_OFFSET must be at least APB_DATA_WIDTH/8");
    end
    if (WAIT_STATES > 15) begin : g_err_wait
        $error("WAIT_STATES must be in 0..15");
    end
    if ((NO_APB_REGS < 1) || (NO_APB_REGS > 1024)) begin : g_err_nregs
        $error("NO_APB_REGS must be in 1..1024");
    end

    logic [1:0]                                 state_q, state_d, phase;
    logic [3:0]                                 cnt_q, cnt_d;
    logic [NO_APB_REGS-1:0][REG_DATA_WIDTH-1:0] reg_q, reg_d;
    logic [NO_APB_REGS-1:0]                     pulse_q, pulse_d;

    // Address decode
    logic [APB_ADDR_WIDTH-1:0] off, idx_full;
    logic [IDX_W-1:0]          idx;
    logic                      addr_ok, err, complete, wr_commit, rd_ok;

    assign off      = apb_reg_paddr - BASE_ADDR;
    assign idx_full = off >> OFF_SHIFT;
    assign idx      = idx_full[IDX_W-1:0];
    assign addr_ok  = (apb_reg_paddr >= BASE_ADDR) && ((off & ALIGN_MASK) == '0) &&
                      (idx_full < NREGS_A);
    assign err      = !addr_ok || (apb_reg_pwrite && READ_ONLY[idx]);

    // SETUP is recognised in the very cycle psel rises with penable low, so the
    // registered state only ever holds IDLE or ACCESS and a zero-wait transfer
    // completes in two cycles.
    always_comb begin
        phase = state_q;
        if (state_q == ST_IDLE && apb_reg_psel && !apb_reg_penable) begin
            phase = ST_SETUP;
        end
    end

    assign complete = (state_q == ST_ACCESS) && (cnt_q == WS) &&
                      apb_reg_psel && apb_reg_penable;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (phase)
            ST_SETUP: begin
                state_d = ST_ACCESS;
                cnt_d   = 4'd0;
            end
            ST_ACCESS: begin
                if (!apb_reg_psel || complete) begin
                    // A following setup phase is picked up again from IDLE.
                    state_d = ST_IDLE;
                end else if (cnt_q != WS) begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Write data path
    logic [APB_DATA_WIDTH-1:0] byte_mask;
    logic [REG_DATA_WIDTH-1:0] wmask, wbits;

    always_comb begin
        byte_mask = '0;
        for (int b = 0; b < STRB_W; b++) begin
            if (apb_reg_pstrb[b]) begin
                byte_mask[8*b +: 8] = 8'hFF;
            end
        end
    end

    // Lanes above REG_DATA_WIDTH simply fall off here.
    assign wmask     = byte_mask[REG_DATA_WIDTH-1:0];
    assign wbits     = apb_reg_pwdata[REG_DATA_WIDTH-1:0] & wmask;
    assign wr_commit = complete && apb_reg_pwrite && !err;

    always_comb begin
        reg_d   = reg_q;
        pulse_d = '0;
        for (int i = 0; i < NO_APB_REGS; i++) begin
            if (W1C[i]) begin
                reg_d[i] = reg_q[i] | hw_set_i[i];
            end
            if (wr_commit && (idx == IDX_W'(i))) begin
                pulse_d[i] = 1'b1;
                if (W1C[i]) begin
                    // Set is ORed last so it wins over a clear of the same bit.
                    reg_d[i] = (reg_q[i] & ~wbits) | hw_set_i[i];
                end else begin
                    reg_d[i] = (reg_q[i] & ~wmask) | wbits;
                end
            end
            if (READ_ONLY[i] && hw_ld_i[i]) begin
                reg_d[i] = hw_ld_data_i[i];
            end
        end
    end

    always_ff @(posedge p_clk) begin
        if (p_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            reg_q   <= reg_init_i;
            pulse_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            reg_q   <= reg_d;
            pulse_q <= pulse_d;
        end
    end

    // Outputs are forced to their reset view combinationally while p_rst is high.
    assign rd_ok           = complete && !apb_reg_pwrite && !err && !p_rst;
    assign apb_reg_pready  = complete && !p_rst;
    assign apb_reg_pslverr = complete && err && !p_rst;
    assign apb_reg_prdata  = rd_ok ? APB_DATA_WIDTH'(reg_q[idx]) : '0;
    assign reg_q_o         = p_rst ? reg_init_i : reg_q;
    assign reg_wr_pulse_o  = p_rst ? '0 : pulse_q;

    logic unused_bits;
    assign unused_bits = ^{apb_reg_pprot, apb_reg_pwdata, byte_mask, off};

endmodule

// File: tb/tb_apb_regs_bank.sv
module tb_apb_regs_bank;

    localparam int unsigned      N    = 16;
    localparam int unsigned      RW   = 16;
    localparam int unsigned      WS   = 2;
    localparam logic [31:0]      BASE = 32'h0013_0000;
    localparam logic [N-1:0]     RO_MASK  = 16'h0020;
    localparam logic [N-1:0]     W1C_MASK = 16'h0002;

    logic                    clk;
    logic                    p_rst;
    logic [31:0]             paddr;
    logic [2:0]              pprot;
    logic                    psel, penable, pwrite;
    logic [31:0]             pwdata;
    logic [3:0]              pstrb;
    logic                    pready, pslverr;
    logic [31:0]             prdata;
    logic [N-1:0][RW-1:0]    reg_init, hw_set, hw_ld_data, reg_q;
    logic [N-1:0]            hw_ld, wr_pulse;

    int n_checks = 0;
    int n_errors = 0;

    logic [RW-1:0] ref_regs [N];
    logic [RW-1:0] init_val [N];

    apb_regs_bank #(
        .NO_APB_REGS    (N),
        .APB_ADDR_WIDTH (32),
        .APB_DATA_WIDTH (32),
        .REG_DATA_WIDTH (RW),
        .BASE_ADDR      (BASE),
        .ADDR_OFFSET    (4),
        .READ_ONLY      (RO_MASK),
        .W1C            (W1C_MASK),
        .WAIT_STATES    (WS)
    ) u_dut (
        .p_clk           (clk),
        .p_rst           (p_rst),
        .apb_reg_paddr   (paddr),
        .apb_reg_pprot   (pprot),
        .apb_reg_psel    (psel),
        .apb_reg_penable (penable),
        .apb_reg_pwrite  (pwrite),
        .apb_reg_pwdata  (pwdata),
        .apb_reg_pstrb   (pstrb),
        .apb_reg_pready  (pready),
        .apb_reg_prdata  (prdata),
        .apb_reg_pslverr (pslverr),
        .reg_init_i      (reg_init),
        .hw_set_i        (hw_set),
        .hw_ld_i         (hw_ld),
        .hw_ld_data_i    (hw_ld_data),
        .reg_q_o         (reg_q),
        .reg_wr_pulse_o  (wr_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [N*RW-1:0] ref_vec();
        logic [N*RW-1:0] v;
        for (int i = 0; i < N; i++) v[i*RW +: RW] = ref_regs[i];
        return v;
    endfunction

    function automatic logic [N*RW-1:0] init_vec();
        logic [N*RW-1:0] v;
        for (int i = 0; i < N; i++) v[i*RW +: RW] = init_val[i];
        return v;
    endfunction

    // One APB transfer; reports the number of access-phase cycles up to and
    // including the one with pready.
    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, output logic [31:0] rdata,
                            output logic err, output int cyc);
        logic done;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb;
        pprot = 3'($urandom_range(0, 7));
        @(posedge clk); #1;
        penable = 1'b1;
        cyc = 0; rdata = '0; err = 1'b0; done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            cyc++;
            if (pready) begin
                rdata = prdata;
                err   = pslverr;
                done  = 1'b1;
            end
        end
        if (!done) check_val("pready_timeout", 256'(pready), 256'(1));
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    // Transfer checked against the reference model, then one cycle later the
    // write pulse and full register contents.
    task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, input string tag);
        logic [31:0] off, rdata, exp_rdata;
        logic        err, legal, exp_err, commit;
        int          idx, cyc;
        logic [RW-1:0] m, wm;
        logic [N-1:0]  exp_pulse;
        off       = addr - BASE;
        legal     = (addr >= BASE) && (off % 4 == 0) && (off / 4 < N);
        idx       = legal ? int'(off / 4) : 0;
        exp_err   = !legal || (wr && RO_MASK[idx]);
        exp_rdata = (!wr && !exp_err) ? {16'h0, ref_regs[idx]} : 32'h0;
        apb_xfer(wr, addr, wdata, strb, rdata, err, cyc);
        check_val({tag, "_cycles"}, 256'(cyc), 256'(WS + 1));
        check_val({tag, "_pslverr"}, 256'(err), 256'(exp_err));
        if (!wr) check_val({tag, "_prdata"}, 256'(rdata), 256'(exp_rdata));
        commit = wr && !exp_err;
        if (commit) begin
            m  = {strb[1] ? 8'hFF : 8'h00, strb[0] ? 8'hFF : 8'h00};
            wm = wdata[RW-1:0] & m;
            if (W1C_MASK[idx]) ref_regs[idx] = (ref_regs[idx] & ~wm) | hw_set[idx];
            else               ref_regs[idx] = (ref_regs[idx] & ~m) | wm;
        end
        exp_pulse = commit ? (N'(1) << idx) : '0;
        @(negedge clk);
        check_val({tag, "_pulse"}, 256'(wr_pulse), 256'(exp_pulse));
        check_val({tag, "_regs"}, 256'(reg_q), 256'(ref_vec()));
    endtask

    initial begin
        p_rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
        hw_set = '0; hw_ld = '0; hw_ld_data = '0;
        for (int i = 0; i < N; i++) init_val[i] = '0;
        init_val[1] = 16'h00F0;
        init_val[3] = 16'hA5A5;
        init_val[9] = 16'h1357;
        for (int i = 0; i < N; i++) begin
            reg_init[i] = init_val[i];
            ref_regs[i] = init_val[i];
        end

        // Reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_regs", 256'(reg_q), 256'(init_vec()));
        check_val("rst_pready", 256'(pready), 256'(0));
        @(posedge clk); #1;
        p_rst = 1'b0;
        @(negedge clk);
        check_val("rst_reg3", 256'(reg_q[3]), 256'(16'hA5A5));
        check_val("rst_pready_after", 256'(pready), 256'(0));
        check_val("rst_pulse", 256'(wr_pulse), 256'(0));

        // Strobed write and readback
        do_xfer(1'b1, BASE + 32'h8, 32'h1234_BEEF, 4'b0001, "strb_wr");
        check_val("strb_reg2", 256'(reg_q[2]), 256'(16'h00EF));
        @(negedge clk);
        check_val("strb_pulse_once", 256'(wr_pulse), 256'(0));
        do_xfer(1'b0, BASE + 32'h8, 32'h0, 4'h0, "strb_rd");

        // Illegal accesses
        do_xfer(1'b0, BASE + 32'h2, 32'h0, 4'h0, "misalign_rd");
        do_xfer(1'b1, BASE + 32'h40, 32'hFFFF_FFFF, 4'hF, "oob_wr");
        do_xfer(1'b0, BASE - 32'h4, 32'h0, 4'h0, "below_rd");

        // Read-only register and hardware load
        do_xfer(1'b1, BASE + 32'h14, 32'h0000_FFFF, 4'hF, "ro_wr");
        @(posedge clk); #1;
        hw_ld[5] = 1'b1; hw_ld_data[5] = 16'h0042;
        @(posedge clk); #1;
        hw_ld = '0;
        ref_regs[5] = 16'h0042;
        @(negedge clk);
        check_val("ro_load", 256'(reg_q[5]), 256'(16'h0042));

        // W1C with simultaneous set
        hw_set[1] = 16'h0010;
        ref_regs[1] = ref_regs[1] | 16'h0010;
        do_xfer(1'b1, BASE + 32'h4, 32'h0000_0030, 4'hF, "w1c");
        check_val("w1c_reg1", 256'(reg_q[1]), 256'(16'h00D0));
        hw_set = '0;
        do_xfer(1'b1, BASE + 32'h4, 32'h0000_0080, 4'hF, "w1c_plain");

        // Abort mid-ACCESS
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = BASE + 32'h10;
        pwdata = 32'h0000_FFFF; pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        check_val("abort_pready", 256'(pready), 256'(0));
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check_val("abort_pulse", 256'(wr_pulse), 256'(0));
            check_val("abort_regs", 256'(reg_q), 256'(ref_vec()));
        end

        // Reset during ACCESS of a write
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = BASE + 32'h1C;
        pwdata = 32'h0000_FFFF; pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        check_val("mrst_pready0", 256'(pready), 256'(0));
        @(posedge clk); #1;
        p_rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check_val("mrst_pready", 256'(pready), 256'(0));
            check_val("mrst_regs", 256'(reg_q), 256'(init_vec()));
            @(posedge clk); #1;
        end
        p_rst = 1'b0; psel = 1'b0; penable = 1'b0;
        for (int i = 0; i < N; i++) ref_regs[i] = init_val[i];
        @(negedge clk);
        check_val("mrst_after_regs", 256'(reg_q), 256'(ref_vec()));
        check_val("mrst_after_pulse", 256'(wr_pulse), 256'(0));
        do_xfer(1'b1, BASE + 32'h1C, 32'h0000_5A5A, 4'b0011, "mrst_next");

        // Zero-strobe write still commits and pulses
        do_xfer(1'b1, BASE + 32'h24, 32'hFFFF_FFFF, 4'b0000, "zero_strb");

        // Randomised traffic
        for (int t = 0; t < 120; t++) begin
            logic [31:0] a;
            a = BASE + 32'($urandom_range(0, 17)) * 32'd4;
            if ($urandom_range(0, 9) == 0) a = a + 32'($urandom_range(1, 3));
            if ($urandom_range(0, 19) == 0) a = BASE - 32'($urandom_range(1, 64));
            do_xfer(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
